mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data word width in bits.
REQ-002 Parameter ADDR_SPACE, default 9, SHALL set the address width in bits (512 words).
REQ-003 clk  in  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 clr  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 i_req / d_req  in  1 each  SHALL be the request from the instruction-fetch port / data port.
REQ-006 i_addr / d_addr  in  ADDR_SPACE each  SHALL be the word address of each port.
REQ-007 d_we  in  1  SHALL select data-port write (1) or read (0); the instruction port is read-only.
REQ-008 d_wdata  in  DATA_WIDTH  SHALL be the data-port write data.
REQ-009 i_ack / d_ack  out  1 each  SHALL be a one-cycle completion pulse per port.
REQ-010 rdata  out  DATA_WIDTH  SHALL be the registered read result, valid while the matching ack is high and held until the next capture.
REQ-011 busy  out  1  SHALL be high in every state except IDLE.
REQ-012 grant_d  out  1  SHALL be high while the current transaction belongs to the data port.
REQ-013 ram_addr  out  ADDR_SPACE, ram_datain  out  DATA_WIDTH  SHALL drive the RAM address and write data.
REQ-014 ram_read / ram_write / ram_enable  out  1 each  SHALL drive the RAM strobes; the RAM acts on the rising edge of ram_enable.
REQ-015 ram_dataout  in  DATA_WIDTH  SHALL be the RAM read data.

Function
REQ-016 FSM states SHALL be IDLE, SETUP, STROBE and CAPTURE.
REQ-017 IDLE: if any req is high, the FSM SHALL latch the winner's address, wdata and direction into internal registers, set grant_d, and go to SETUP; otherwise it SHALL stay in IDLE.
REQ-018 SETUP: ram_addr, ram_datain, ram_read and ram_write SHALL be driven from the latched values with ram_enable=0; next state SHALL be STROBE.
REQ-019 STROBE: ram_enable SHALL be 1 for exactly one cycle with address, data and direction held stable; next state SHALL be CAPTURE.
REQ-020 CAPTURE: ram_enable SHALL be 0; for a read, rdata SHALL load ram_dataout at the end of CAPTURE; next state SHALL be IDLE.
REQ-021 The winning port's ack SHALL pulse for exactly the one cycle following CAPTURE (the IDLE entry cycle), and rdata SHALL be valid in that cycle.
REQ-022 For a write, rdata SHALL NOT change.
REQ-023 ram_read and ram_write SHALL never be high together, and both SHALL be 0 in IDLE.
REQ-024 Latency: with the request sampled at edge N, ack SHALL be high in the cycle after edge N+3, giving 4 cycles per transaction and one transaction per 4 cycles.
REQ-025 Arbitration SHALL be round-robin: when both reqs are high in IDLE, the port not granted most recently wins, and a lone requester always wins.
REQ-026 After reset, the first simultaneous request SHALL go to the instruction port.
REQ-027 Requesters SHALL hold req, addr, wdata and d_we stable until ack; changes to these inputs after the IDLE sample SHALL NOT affect the transaction in flight.
REQ-028 A req still high in the ack cycle SHALL be sampled as a new request in that same IDLE cycle.
REQ-029 Requests arriving while busy SHALL wait without being dropped.

Reset
REQ-030 clr=0 SHALL immediately force state IDLE and drive ram_enable, ram_read, ram_write, i_ack, d_ack, busy and grant_d to 0.
REQ-031 clr=0 SHALL also clear rdata, ram_addr and ram_datain to 0, and set round-robin priority to the instruction port.
REQ-032 If reset asserts mid-transaction, no ack SHALL be issued; a write whose ram_enable rise has already occurred is complete in the RAM.
REQ-033 After clr releases, the first transaction SHALL begin only on a rising clk edge.

Verification
REQ-034 i_req=1, i_addr=0 with the RAM word 0 = 32'h9B180019 -> SETUP/STROBE/CAPTURE sequence, i_ack high 4 cycles after the sample, rdata=32'h9B180019.
REQ-035 d_req=1, d_we=1, d_addr=9'h0A, d_wdata=32'hDEADBEEF, then a d_req read of 9'h0A -> second d_ack with rdata=32'hDEADBEEF, and ram_write=1 only in SETUP/STROBE of the first transaction.
REQ-036 i_req and d_req held high continuously -> grants alternate I,D,I,D with acks spaced 4 cycles, the first grant going to I.
REQ-037 Check on every cycle of all scenarios -> ram_enable is high exactly one cycle per transaction, address is stable from SETUP through CAPTURE, ram_read&ram_write is never 1.
REQ-038 clr pulsed low during STROBE of a read -> outputs reach reset values asynchronously, no ack, and a following request completes normally in 4 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter between an instruction-fetch port and a
// data port, sequencing a single-port RAM through SETUP/STROBE/CAPTURE.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_SPACE = 9
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  i_req,
    input  logic                  d_req,
    input  logic [ADDR_SPACE-1:0] i_addr,
    input  logic [ADDR_SPACE-1:0] d_addr,
    input  logic                  d_we,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  i_ack,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  grant_d,
    output logic [ADDR_SPACE-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_datain,
    output logic                  ram_read,
    output logic                  ram_write,
    output logic                  ram_enable,
    input  logic [DATA_WIDTH-1:0] ram_dataout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        STROBE  = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_gnt_d;
    logic                  r_prio_d;
    logic                  r_we;
    logic [ADDR_SPACE-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_iack;
    logic                  r_dack;
    logic                  r_rd;
    logic                  r_wr;
    logic                  r_en;
    logic                  w_take;
    logic                  w_win_d;
    logic                  w_we_nx;
    logic                  w_rd_nx;
    logic                  w_wr_nx;
    logic                  w_en_nx;

    // Next state and next RAM strobes; strobes are registered so they are glitch-free.
    always_comb begin
        w_take  = i_req | d_req;
        w_win_d = d_req & (~i_req | r_prio_d);
        w_next  = r_state;
        w_we_nx = r_we;
        unique case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_next  = SETUP;
                    w_we_nx = w_win_d & d_we;
                end
            end
            SETUP:   w_next = STROBE;
            STROBE:  w_next = CAPTURE;
            CAPTURE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
        w_en_nx = (w_next == STROBE);
        w_rd_nx = ((w_next == SETUP) | (w_next == STROBE)) & ~w_we_nx;
        w_wr_nx = ((w_next == SETUP) | (w_next == STROBE)) & w_we_nx;
    end

    // State register and registered RAM strobes.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= IDLE;
            r_en    <= 1'b0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_en    <= w_en_nx;
            r_rd    <= w_rd_nx;
            r_wr    <= w_wr_nx;
        end
    end

    // Latch the winner's request and rotate priority away from it.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_gnt_d  <= 1'b0;
            r_prio_d <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (r_state == IDLE && w_take) begin
            r_gnt_d  <= w_win_d;
            r_prio_d <= ~w_win_d;
            r_we     <= w_win_d & d_we;
            r_addr   <= w_win_d ? d_addr : i_addr;
            r_wdata  <= w_win_d ? d_wdata : '0;
        end
    end

    // Ack pulse and read capture happen together at the end of CAPTURE.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_iack  <= 1'b0;
            r_dack  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_iack <= (r_state == CAPTURE) & ~r_gnt_d;
            r_dack <= (r_state == CAPTURE) & r_gnt_d;
            if (r_state == CAPTURE && !r_we) begin
                r_rdata <= ram_dataout;
            end
        end
    end

    assign busy       = (r_state != IDLE);
    assign grant_d    = r_gnt_d & busy;
    assign i_ack      = r_iack;
    assign d_ack      = r_dack;
    assign rdata      = r_rdata;
    assign ram_addr   = r_addr;
    assign ram_datain = r_wdata;
    assign ram_read   = r_rd;
    assign ram_write  = r_wr;
    assign ram_enable = r_en;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors, corner sequences and random traffic
// against a transaction-level model of the arbiter and a RAM model.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          i_req = 1'b0;
    logic          d_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [AW-1:0] d_addr = '0;
    logic          d_we = 1'b0;
    logic [DW-1:0] d_wdata = '0;
    logic          i_ack;
    logic          d_ack;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          grant_d;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_datain;
    logic          ram_read;
    logic          ram_write;
    logic          ram_enable;
    logic [DW-1:0] ram_dataout = '0;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_SPACE(AW)) dut (
        .clk(clk), .clr(clr),
        .i_req(i_req), .d_req(d_req),
        .i_addr(i_addr), .d_addr(d_addr),
        .d_we(d_we), .d_wdata(d_wdata),
        .i_ack(i_ack), .d_ack(d_ack),
        .rdata(rdata), .busy(busy), .grant_d(grant_d),
        .ram_addr(ram_addr), .ram_datain(ram_datain),
        .ram_read(ram_read), .ram_write(ram_write),
        .ram_enable(ram_enable), .ram_dataout(ram_dataout)
    );

    always #5 clk = ~clk;

    // RAM acts on the rising edge of ram_enable
    logic [DW-1:0] ram_mem [512];
    always @(posedge ram_enable) begin
        if (ram_write) ram_mem[ram_addr] <= ram_datain;
        if (ram_read) ram_dataout <= ram_mem[ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
        end
    endtask

    // transaction-level reference: grant edge index, winner, expected memory
    int            cyc = 0;
    bit            m_valid = 1'b0;
    int            m_g = 0;
    bit            m_port = 1'b0;
    bit            m_we = 1'b0;
    bit            m_prio_d = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;
    logic [DW-1:0] m_next = '0;
    logic [DW-1:0] exp_mem [512];

    initial forever begin
        @(posedge clk);
        cyc++;
        if (clr) begin
            if (m_valid && cyc == m_g + 3 && !m_we) m_rdata = m_next;
            if ((!m_valid || cyc >= m_g + 4) && (i_req || d_req)) begin
                m_port   = d_req && (!i_req || m_prio_d);
                m_prio_d = !m_port;
                m_g      = cyc;
                m_valid  = 1'b1;
                m_we     = m_port && d_we;
                m_addr   = m_port ? d_addr : i_addr;
                m_wdata  = d_wdata;
                if (m_we) exp_mem[m_addr] = m_wdata;
                else m_next = exp_mem[m_addr];
            end
        end
    end

    // every-cycle output check on the falling edge
    int ph;
    bit in_txn;
    initial forever begin
        @(negedge clk);
        if (!clr) begin
            m_valid = 1'b0; m_prio_d = 1'b0;
            m_rdata = '0; m_addr = '0; m_wdata = '0;
            chk("rst_busy", busy, 0);
            chk("rst_grant_d", grant_d, 0);
            chk("rst_en", ram_enable, 0);
            chk("rst_rd", ram_read, 0);
            chk("rst_wr", ram_write, 0);
            chk("rst_acks", {i_ack, d_ack}, 0);
            chk("rst_rdata", rdata, 0);
            chk("rst_addr", ram_addr, 0);
            chk("rst_datain", ram_datain, 0);
        end else begin
            ph = m_valid ? cyc - m_g : 99;
            in_txn = (ph <= 2);
            chk("busy", busy, in_txn);
            chk("grant_d", grant_d, in_txn && m_port);
            chk("ram_enable", ram_enable, ph == 1);
            chk("ram_write", ram_write, m_we && ph <= 1);
            chk("ram_read", ram_read, !m_we && ph <= 1);
            chk("i_ack", i_ack, ph == 3 && !m_port);
            chk("d_ack", d_ack, ph == 3 && m_port);
            chk("rdata", rdata, m_rdata);
            chk("ram_addr", ram_addr, m_addr);
            if (in_txn && m_we) chk("ram_datain", ram_datain, m_wdata);
        end
    end

    typedef struct {
        bit            ir;
        bit            dr;
        logic [AW-1:0] ia;
        logic [AW-1:0] da;
        bit            we;
        logic [DW-1:0] wd;
        bit            exp_d;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input vec_t v, input int idx);
        int k;
        bit got;
        i_req = v.ir; i_addr = v.ia;
        d_req = v.dr; d_addr = v.da; d_we = v.we; d_wdata = v.wd;
        k = 0;
        got = 1'b0;
        while (!got && k < 8) begin
            @(posedge clk); #1;
            k++;
            got = v.exp_d ? d_ack : i_ack;
        end
        i_req = 1'b0; d_req = 1'b0;
        chk($sformatf("vec%0d_latency", idx), k, 4);
        chk($sformatf("vec%0d_other_ack", idx), v.exp_d ? i_ack : d_ack, 0);
        chk($sformatf("vec%0d_rdata", idx), rdata, v.exp_rd);
    endtask

    task automatic pulse_reset();
        clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;
    endtask

    initial begin
        int n;
        int k;
        int rp;
        bit seen;
        for (int i = 0; i < 512; i++) begin
            ram_mem[i] = 32'hA500_0000 | 32'(i);
            exp_mem[i] = 32'hA500_0000 | 32'(i);
        end
        ram_mem[0] = 32'h9B18_0019;
        exp_mem[0] = 32'h9B18_0019;

        vecs[0] = '{1'b1, 1'b0, 9'h000, 9'h000, 1'b0, 32'h0, 1'b0, 32'h9B18_0019};
        vecs[1] = '{1'b0, 1'b1, 9'h000, 9'h00A, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h9B18_0019};
        vecs[2] = '{1'b0, 1'b1, 9'h000, 9'h00A, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b0, 9'h00A, 9'h000, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 1'b1, 9'h000, 9'h1FF, 1'b1, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 1'b0, 9'h1FF, 9'h000, 1'b0, 32'h0, 1'b0, 32'h1234_5678};
        vecs[6] = '{1'b0, 1'b1, 9'h000, 9'h001, 1'b0, 32'h0, 1'b1, 32'hA500_0001};

        repeat (3) @(posedge clk);
        #1 clr = 1'b1;

        for (int v = 0; v < 7; v++) run_vec(vecs[v], v);

        // both ports requesting continuously: I first after reset, then alternate
        pulse_reset();
        i_req = 1'b1; i_addr = 9'h002;
        d_req = 1'b1; d_addr = 9'h003; d_we = 1'b0;
        n = 0;
        k = 0;
        while (k < 20 && n < 4) begin
            @(posedge clk); #1;
            k++;
            if (i_ack || d_ack) begin
                chk("alt_port", d_ack, n % 2);
                chk("alt_time", k, 4 * (n + 1));
                chk("alt_rdata", rdata, (n % 2) ? 32'hA500_0003 : 32'hA500_0002);
                n++;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        chk("alt_count", n, 4);

        // reset during STROBE of a read
        i_req = 1'b1; i_addr = 9'h005;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("strobe_en", ram_enable, 1);
        clr = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_en", ram_enable, 0);
        chk("async_rd", ram_read, 0);
        chk("async_rdata", rdata, 0);
        chk("async_addr", ram_addr, 0);
        i_req = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (i_ack || d_ack) seen = 1'b1;
        end
        chk("rst_no_ack", seen, 0);
        clr = 1'b1;
        i_req = 1'b1; i_addr = 9'h005;
        k = 0;
        while (k < 8 && !i_ack) begin
            @(posedge clk); #1;
            k++;
        end
        i_req = 1'b0;
        chk("post_rst_latency", k, 4);
        chk("post_rst_rdata", rdata, 32'hA500_0005);

        // random traffic; granted port scrambles its inputs while in flight
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            rp = m_valid ? cyc - m_g : 99;
            if (m_valid && !m_port && rp <= 2) begin
                i_addr = AW'($urandom);
            end else if (!i_req || (m_valid && !m_port && rp == 3)) begin
                i_req  = 1'($urandom_range(0, 1));
                i_addr = AW'($urandom_range(0, 15));
            end
            if (m_valid && m_port && rp <= 2) begin
                d_addr  = AW'($urandom);
                d_wdata = $urandom;
                d_we    = 1'($urandom_range(0, 1));
            end else if (!d_req || (m_valid && m_port && rp == 3)) begin
                d_req   = 1'($urandom_range(0, 1));
                d_addr  = AW'($urandom_range(0, 15));
                d_wdata = $urandom;
                d_we    = 1'($urandom_range(0, 1));
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
